fft8_pipe: RTL and testbench

- Parametrised, fully pipelined 8-point radix-2 DIT FFT on signed fixed-point complex samples; successor to the fixed 6-bit butterfly/flop chain.
- Accepts one complete 8-sample frame per cycle through a valid/ready handshake and returns X[0..7] in natural order after 3 register stages.
- Adds per-frame scaling mode, saturation with a sticky overflow flag, backpressure, and exact fixed-point twiddles.
- Sits between the sample framer and the spectrum post-processing logic.

---
 rtl/fft8_pkg.sv | 64 ++++++
 rtl/fft_bfly.sv | 67 ++++++
 rtl/fft8_pipe.sv | 122 ++++++++++++
 tb/tb_fft8_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared constants and arithmetic helpers for the 8-point pipelined FFT.
// Holds the twiddle constant, the per-stage index tables and the round/saturate helpers.
package fft8_pkg;

  // round(2^(tw_w-2) / sqrt(2)) by integer square root of 2^(2*(tw_w-2)-1); valid for tw_w <= 32
  function automatic int tw_c(input int tw_w);
    longint v, r, t;
    v = longint'(1) << (2 * tw_w - 5);
    r = 0;
    for (int b = 30; b >= 0; b--) begin
      t = r + (longint'(1) << b);
      if (t * t <= v) r = t;
    end
    if (4 * v >= (2 * r + 1) * (2 * r + 1)) r = r + 1;
    return int'(r);
  endfunction

  function automatic int bitrev(input int n);
    case (n)
      0: return 0;
      1: return 4;
      2: return 2;
      3: return 6;
      4: return 1;
      5: return 5;
      6: return 3;
      default: return 7;
    endcase
  endfunction

  // Upper leg of butterfly j in stage s; the lower leg sits 2^s positions above it
  function automatic int bfly_top(input int s, input int j);
    int h;
    h = 1 << s;
    return (j / h) * 2 * h + (j % h);
  endfunction

  // Twiddle exponent k of W8^k used by butterfly j in stage s
  function automatic int w_idx(input int s, input int j);
    case (s)
      0: return 0;
      1: return (j % 2) * 2;
      default: return j;
    endcase
  endfunction

  function automatic longint rnd_shift(input longint v, input int sh);
    return (v + (longint'(1) << (sh - 1))) >>> sh;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input longint v, input int w);
    return (v != sat(v, w));
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Radix-2 DIT butterfly: twiddle multiply (W0/W2 bypassed), add/sub, optional halving,
// saturation back to DATA_W and an overflow indication. Purely combinational.
module fft_bfly
  import fft8_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int W_IDX  = 0
) (
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  input  logic              scale,
  output logic [DATA_W-1:0] x_re,
  output logic [DATA_W-1:0] x_im,
  output logic [DATA_W-1:0] y_re,
  output logic [DATA_W-1:0] y_im,
  output logic              ovf
);

  localparam longint C  = longint'(tw_c(TW_W));
  localparam longint WR = (W_IDX == 1) ? C : -C;
  localparam longint WI = -C;

  longint ar, ai, br, bi, wb_re, wb_im, xr, xi, yr, yi;

  always_comb begin
    ar = longint'($signed(a_re));
    ai = longint'($signed(a_im));
    br = longint'($signed(b_re));
    bi = longint'($signed(b_im));
    case (W_IDX)
      0: begin
        wb_re = br;
        wb_im = bi;
      end
      2: begin
        wb_re = bi;
        wb_im = -br;
      end
      default: begin
        wb_re = rnd_shift(br * WR - bi * WI, TW_W - 2);
        wb_im = rnd_shift(br * WI + bi * WR, TW_W - 2);
      end
    endcase
    xr = ar + wb_re;
    xi = ai + wb_im;
    yr = ar - wb_re;
    yi = ai - wb_im;
    if (scale) begin
      xr = (xr + 1) >>> 1;
      xi = (xi + 1) >>> 1;
      yr = (yr + 1) >>> 1;
      yi = (yi + 1) >>> 1;
    end
  end

  // Halved results still pass through the clamp: a full-scale complex b through W1/W3 can exceed range
  assign x_re = DATA_W'(sat(xr, DATA_W));
  assign x_im = DATA_W'(sat(xi, DATA_W));
  assign y_re = DATA_W'(sat(yr, DATA_W));
  assign y_im = DATA_W'(sat(yi, DATA_W));
  assign ovf  = sat_hit(xr, DATA_W) | sat_hit(xi, DATA_W) |
                sat_hit(yr, DATA_W) | sat_hit(yi, DATA_W);

endmodule

// File: rtl/fft8_pipe.sv
// Fully pipelined 8-point radix-2 DIT FFT: one frame per cycle, natural-order output
// after three register stages, global stall on output backpressure, sticky overflow flag.
module fft8_pipe
  import fft8_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*DATA_W-1:0] in_re,
  input  logic [8*DATA_W-1:0] in_im,
  input  logic                in_scale,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*DATA_W-1:0] out_re,
  output logic [8*DATA_W-1:0] out_im,
  output logic                ovf,
  input  logic                ovf_clr
);

  logic              adv, stage_sat;
  logic              vld_p0, vld_p1, vld_p2;
  logic              scl_p0, scl_p1;
  logic [2:0]        src_vld, src_scl;
  logic [11:0]       bf_ovf;
  logic [DATA_W-1:0] re_p0 [8], im_p0 [8];
  logic [DATA_W-1:0] re_p1 [8], im_p1 [8];
  logic [DATA_W-1:0] re_p2 [8], im_p2 [8];
  logic [DATA_W-1:0] src_re [3][8], src_im [3][8];
  logic [DATA_W-1:0] bo_re [3][8], bo_im [3][8];

  assign adv       = !vld_p2 | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;
  assign src_vld   = {vld_p1, vld_p0, in_valid};
  assign src_scl   = {scl_p1, scl_p0, in_scale};
  assign stage_sat = |(bf_ovf & {{4{src_vld[2]}}, {4{src_vld[1]}}, {4{src_vld[0]}}});

  for (genvar i = 0; i < 8; i++) begin : g_io
    assign src_re[0][i] = in_re[bitrev(i)*DATA_W +: DATA_W];
    assign src_im[0][i] = in_im[bitrev(i)*DATA_W +: DATA_W];
    assign src_re[1][i] = re_p0[i];
    assign src_im[1][i] = im_p0[i];
    assign src_re[2][i] = re_p1[i];
    assign src_im[2][i] = im_p1[i];
    assign out_re[i*DATA_W +: DATA_W] = re_p2[i];
    assign out_im[i*DATA_W +: DATA_W] = im_p2[i];
  end

  for (genvar s = 0; s < 3; s++) begin : g_stage
    for (genvar j = 0; j < 4; j++) begin : g_bf
      localparam int T = bfly_top(s, j);
      localparam int B = T + (1 << s);
      fft_bfly #(
        .DATA_W(DATA_W),
        .TW_W  (TW_W),
        .W_IDX (w_idx(s, j))
      ) u_bf (
        .a_re (src_re[s][T]),
        .a_im (src_im[s][T]),
        .b_re (src_re[s][B]),
        .b_im (src_im[s][B]),
        .scale(src_scl[s]),
        .x_re (bo_re[s][T]),
        .x_im (bo_im[s][T]),
        .y_re (bo_re[s][B]),
        .y_im (bo_im[s][B]),
        .ovf  (bf_ovf[s*4+j])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (adv) begin
        vld_p0 <= in_valid;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end
      if (adv && stage_sat) ovf <= 1'b1;
      else if (ovf_clr)     ovf <= 1'b0;
    end
  end

  // S1 / S2 boundary registers
  always_ff @(posedge clk) begin
    if (adv) begin
      scl_p0 <= in_scale;
      scl_p1 <= scl_p0;
      for (int k = 0; k < 8; k++) begin
        re_p0[k] <= bo_re[0][k];
        im_p0[k] <= bo_im[0][k];
        re_p1[k] <= bo_re[1][k];
        im_p1[k] <= bo_im[1][k];
      end
    end
  end

  // S3 drives the outputs, so it is cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        re_p2[k] <= '0;
        im_p2[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < 8; k++) begin
        re_p2[k] <= bo_re[2][k];
        im_p2[k] <= bo_im[2][k];
      end
    end
  end

endmodule

// File: tb/tb_fft8_pipe.sv
// Directed-vector bench for fft8_pipe: table of frames with hand-computed spectra,
// plus sequences for overflow stickiness, mixed scale modes, backpressure and reset.
module tb_fft8_pipe;

  localparam int DW = 16;
  localparam int TW = 16;
  localparam logic [8*DW-1:0] Z = '0;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_scale, out_valid, out_ready, ovf, ovf_clr;
  logic [8*DW-1:0] in_re, in_im, out_re, out_im;

  always #5 clk = ~clk;

  fft8_pipe #(.DATA_W(DW), .TW_W(TW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .in_scale (in_scale),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_re   (out_re),
    .out_im   (out_im),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  typedef struct {
    logic [8*DW-1:0] re;
    logic [8*DW-1:0] im;
    logic            scale;
    logic [8*DW-1:0] xr;
    logic [8*DW-1:0] xi;
    int              tol;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  function automatic logic [8*DW-1:0] pk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    int t [8];
    logic [8*DW-1:0] r;
    t = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int n = 0; n < 8; n++) r[n*DW +: DW] = t[n][DW-1:0];
    return r;
  endfunction

  function automatic int field(input logic [8*DW-1:0] v, input int k);
    return int'($signed(v[k*DW +: DW]));
  endfunction

  task automatic drive(input vec_t v);
    in_re    = v.re;
    in_im    = v.im;
    in_scale = v.scale;
    in_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, got, sent, extra, held, n;
    int got_x0 [2];
    logic stalled_prev;

    vecs[0] = '{re: pk8(100, 0, 0, 0, 0, 0, 0, 0), im: Z, scale: 1'b0,
                xr: pk8(100, 100, 100, 100, 100, 100, 100, 100), xi: Z, tol: 0, exp_ovf: 1'b0};
    vecs[1] = '{re: pk8(10, 10, 10, 10, 10, 10, 10, 10), im: Z, scale: 1'b0,
                xr: pk8(80, 0, 0, 0, 0, 0, 0, 0), xi: Z, tol: 0, exp_ovf: 1'b0};
    vecs[2] = '{re: pk8(10, 10, 10, 10, 10, 10, 10, 10), im: Z, scale: 1'b1,
                xr: pk8(10, 0, 0, 0, 0, 0, 0, 0), xi: Z, tol: 0, exp_ovf: 1'b0};
    vecs[3] = '{re: pk8(1000, 707, 0, -707, -1000, -707, 0, 707), im: Z, scale: 1'b0,
                xr: pk8(0, 4000, 0, 0, 0, 0, 0, 4000), xi: Z, tol: 2, exp_ovf: 1'b0};
    vecs[4] = '{re: Z, im: pk8(0, 100, 0, 0, 0, 0, 0, 0), scale: 1'b0,
                xr: pk8(0, 71, 100, 71, 0, -71, -100, -71),
                xi: pk8(100, 71, 0, -71, -100, -71, 0, 71), tol: 0, exp_ovf: 1'b0};
    vecs[5] = '{re: pk8(30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000), im: Z, scale: 1'b0,
                xr: pk8(32767, 0, 0, 0, 0, 0, 0, 0), xi: Z, tol: 0, exp_ovf: 1'b1};
    vecs[6] = '{re: pk8(30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000), im: Z, scale: 1'b1,
                xr: pk8(30000, 0, 0, 0, 0, 0, 0, 0), xi: Z, tol: 0, exp_ovf: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_scale = 1'b0; in_re = '0; in_im = '0;
    out_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_out_re0", field(out_re, 0), 0, 0);
    chk("rst_out_im7", field(out_im, 7), 0, 0);
    chk("rst_ovf", int'(ovf), 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1, 0);

    // table-driven frames
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1 chk($sformatf("v%0d_in_ready", i), int'(in_ready), 1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      chk($sformatf("v%0d_latency", i), lat, 3, 0);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("v%0d_re%0d", i, k), field(out_re, k), field(vecs[i].xr, k), vecs[i].tol);
        chk($sformatf("v%0d_im%0d", i, k), field(out_im, k), field(vecs[i].xi, k), vecs[i].tol);
      end
      chk($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].exp_ovf), 0);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
    end

    // sticky overflow, then explicit clear
    @(negedge clk);
    drive(vecs[5]);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("ovf_sticky", int'(ovf), 1, 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0, 0);

    // set beats a simultaneous clear
    ovf_clr = 1'b1;
    drive(vecs[5]);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ovf_set_wins", int'(ovf), 1, 0);
    repeat (4) @(negedge clk);
    chk("ovf_clr_held", int'(ovf), 0, 0);
    ovf_clr = 1'b0;

    // mixed scale modes back to back
    @(negedge clk);
    drive(vecs[5]);
    @(negedge clk);
    drive(vecs[6]);
    @(negedge clk);
    in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got < 2; c++) begin
      if (out_valid) begin
        got_x0[got] = field(out_re, 0);
        got++;
      end
      if (got < 2) @(negedge clk);
    end
    chk("mix_count", got, 2, 0);
    chk("mix_x0_sat", got_x0[0], 32767, 0);
    chk("mix_x0_scaled", got_x0[1], 30000, 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    repeat (4) @(negedge clk);

    // backpressure: out_ready low for cycles 4..6
    sent = 0; got = 0; held = 0; stalled_prev = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      out_ready = !(c >= 4 && c < 7);
      in_valid  = (sent < 5);
      in_scale  = 1'b0;
      n = 11 * (sent + 1);
      in_re = pk8(n, 0, 0, 0, 0, 0, 0, 0);
      in_im = pk8(n + 1, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (stalled_prev) chk("bp_hold", field(out_re, 3), held, 0);
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", int'(in_ready), 0, 0);
        held = field(out_re, 3);
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk("bp_order_re", field(out_re, 0), 11 * (got + 1), 0);
        chk("bp_order_im", field(out_im, 7), 11 * (got + 1) + 1, 0);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got, 5, 0);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    chk("bp_no_dup", extra, 0, 0);

    // reset with three frames in flight
    for (int c = 0; c < 3; c++) begin
      drive(vecs[5]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mid_pre_valid", int'(out_valid), 1, 0);
    chk("mid_pre_ovf", int'(ovf), 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_out_valid", int'(out_valid), 0, 0);
    chk("mid_ovf", int'(ovf), 0, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("mid_re%0d", k), field(out_re, k), 0, 0);
      chk($sformatf("mid_im%0d", k), field(out_im, k), 0, 0);
    end
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("mid_no_stale", extra, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
